reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter SIZE, default 16, the number of ROB entries (power of two); TW = $clog2(SIZE) = 4.
REQ-002 SHALL have ports: clk  in  1  single clock; all state on posedge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: dispatch  in  1  allocate request; dispatch_rd  in  5  destination register; dispatch_pc  in  32  instruction PC.
REQ-005 SHALL have ports: rob_full  out  1  no free entry; rob_entry  out  TW  tag the next dispatch receives (equal to tail).
REQ-006 SHALL have ports: cdb_valid  in  1; cdb_tag  in  TW; cdb_val  in  32; cdb_br_en  in  1; cdb_br_target  in  32  (execution writeback).
REQ-007 SHALL have ports: ready  out  1  head commits this cycle; rdest  out  rob_t  {rds, ROB_val, br_en, br_target}; ROB_commit_tag  out  TW  head index.
REQ-008 SHALL have ports: tag_in1, tag_in2  in  TW; tag1_valid, tag2_valid  in  1  (operand lookups); val1, val2  out  32; val1_ready, val2_ready  out  1.

Function
REQ-009 SHALL hold SIZE entries, each with valid, done, rds, val, br_en, br_target; head and tail pointers are TW bits wide and wrap from SIZE-1 to 0; count is TW+1 bits wide.
REQ-010 SHALL drive rob_full = (count == SIZE), evaluated from the state before the current edge.
REQ-011 On dispatch && !rob_full, SHALL write entry[tail] = {valid=1, done=0, rds=dispatch_rd, br_en=0}, then increment tail.
REQ-012 SHALL ignore dispatch while rob_full, even if a commit occurs in the same cycle; the dispatcher stalls.
REQ-013 On cdb_valid, SHALL set entry[cdb_tag] = {done=1, val=cdb_val, br_en=cdb_br_en, br_target=cdb_br_target}, but only if entry[cdb_tag].valid is set; otherwise the writeback is ignored.
REQ-014 SHALL assert ready combinationally when entry[head].valid && entry[head].done, and drive rdest and ROB_commit_tag from the head entry in the same cycle.
REQ-015 While ready, at the next edge SHALL clear entry[head].valid and increment head; this gives one commit per cycle at most, with a latency of 1 cycle from the CDB write to ready.
REQ-016 Simultaneous dispatch and commit (not full) SHALL leave count unchanged; dispatch alone increments count; commit alone decrements it.
REQ-017 rds = 0 entries SHALL commit normally; ignoring writes to x0 is the consumer's responsibility.
REQ-018 On a commit with rdest.br_en = 1, at that edge SHALL clear all valid/done bits and set head = tail = count = 0, and SHALL drop any dispatch or CDB write in that cycle.
REQ-019 Lookup: for each operand n, when tagn_valid is set, SHALL drive valn/valn_ready = (entry.val, entry.done); when cdb_valid && cdb_tag == tag_inn, SHALL bypass to (cdb_val, 1); otherwise SHALL drive (0, 0).
REQ-020 A CDB write that targets the tail entry being dispatched in the same cycle SHALL be ignored (the entry is not valid yet).

Reset
REQ-021 rst SHALL asynchronously clear all entry valid/done/br_en bits, and SHALL set head = tail = count = 0.
REQ-022 During reset, outputs SHALL be: ready = 0, rob_full = 0, rob_entry = 0, rdest = 0, ROB_commit_tag = 0, val1_ready = val2_ready = 0.
REQ-023 Reset asserted mid-operation SHALL discard all entries; the first dispatch after release receives tag 0.

Structure
REQ-024 rob_t, and the ROB entry struct rob_entry_t, SHALL reside in rv32i_types; SIZE SHALL be taken from a package constant shared with the register file.
REQ-025 The block SHALL be a single module with no sub-modules; the lookup bypass is two instances of the same combinational logic.

Verification
REQ-026 The bench SHALL cover: reset, then 16 dispatches (rd = 1..16) -> tags 0..15, with rob_full = 1 after the 16th; a 17th dispatch is ignored and tail stays at 0.
REQ-027 The bench SHALL cover out-of-order writeback of tags 2, 1, 0 (val = 0x20, 0x10, 0x00) -> commits of tags 0, 1, 2 in order on consecutive cycles, starting the cycle after tag 0's write.
REQ-028 The bench SHALL cover: full ROB, with head done, plus dispatch in the same cycle -> the commit happens, the dispatch is dropped, and count = 15.
REQ-029 The bench SHALL cover a branch entry at tag 3 written with br_en = 1 and br_target = 0x80 while tags 4..6 are valid -> ready with br_target = 0x80, and the next cycle count = 0 and rob_entry = 0.
REQ-030 The bench SHALL cover a lookup of tag 5 with cdb_tag = 5 and cdb_val = 0xDEAD in the same cycle -> val1 = 0xDEAD and val1_ready = 1.
REQ-031 The bench SHALL cover a pointer wrap: 20 dispatch/commit pairs -> tags wrap from 15 to 0 with no loss of data.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I types and reorder buffer sizing
// Purpose: types shared by the reorder buffer and its consumers (commit
// path, register file). No ports.
//   ROB_SIZE    : ROB depth; the register file sizes its tag fields from it
//   rob_t       : commit record presented at the ROB head
//   rob_entry_t : one ROB slot
package rv32i_types;

  localparam int ROB_SIZE = 16;

  typedef struct packed {
    logic [4:0]  rds;
    logic [31:0] ROB_val;
    logic        br_en;
    logic [31:0] br_target;
  } rob_t;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  rds;
    logic [31:0] val;
    logic        br_en;
    logic [31:0] br_target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit reorder buffer with CDB writeback
// Purpose: allocates entries in program order, accepts out-of-order results
// from the CDB, commits one completed entry per cycle from the head and
// flushes everything when a taken branch commits.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   dispatch, dispatch_rd/pc     allocation request
//   rob_full, rob_entry          no free slot / tag of the next allocation
//   cdb_valid/tag/val/br_en/br_target  execution writeback
//   ready, rdest, ROB_commit_tag head commit record and its tag
//   tag_in1/2, tag1/2_valid      operand lookups
//   val1/2, val1/2_ready         lookup results (with CDB bypass)
module reorder_buffer
  import rv32i_types::*;
#(
  parameter int SIZE = ROB_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dispatch,
  input  logic [4:0]               dispatch_rd,
  input  logic [31:0]              dispatch_pc,
  output logic                     rob_full,
  output logic [$clog2(SIZE)-1:0]  rob_entry,
  input  logic                     cdb_valid,
  input  logic [$clog2(SIZE)-1:0]  cdb_tag,
  input  logic [31:0]              cdb_val,
  input  logic                     cdb_br_en,
  input  logic [31:0]              cdb_br_target,
  output logic                     ready,
  output rob_t                     rdest,
  output logic [$clog2(SIZE)-1:0]  ROB_commit_tag,
  input  logic [$clog2(SIZE)-1:0]  tag_in1,
  input  logic [$clog2(SIZE)-1:0]  tag_in2,
  input  logic                     tag1_valid,
  input  logic                     tag2_valid,
  output logic [31:0]              val1,
  output logic [31:0]              val2,
  output logic                     val1_ready,
  output logic                     val2_ready
);

  localparam int TW = $clog2(SIZE);

  rob_entry_t      entries_q [SIZE];
  rob_entry_t      entries_d [SIZE];
  logic [TW-1:0]   head_q, head_d;
  logic [TW-1:0]   tail_q, tail_d;
  logic [TW:0]     count_q, count_d;
  rob_entry_t      head_e;
  logic            do_dispatch, do_commit, flush, cdb_hit;

  // Returns {ready, value}; a same-cycle CDB result wins over the stored one.
  function automatic logic [32:0] lookup(
    input logic          tv,
    input logic [TW-1:0] tag,
    input rob_entry_t    e,
    input logic          cv,
    input logic [TW-1:0] ctag,
    input logic [31:0]   cval
  );
    if (!tv)
      return 33'd0;
    else if (cv && ctag == tag)
      return {1'b1, cval};
    else
      return {e.done, e.val};
  endfunction

  always_comb begin
    head_e      = entries_q[head_q];
    rob_full    = (count_q == (TW+1)'(SIZE));
    do_dispatch = dispatch && !rob_full;
    do_commit   = head_e.valid && head_e.done;
    flush       = do_commit && head_e.br_en;
    // The tail slot is never valid while not full, so a write aimed at the
    // entry being dispatched this cycle falls out here.
    cdb_hit     = cdb_valid && entries_q[cdb_tag].valid;

    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (flush) begin
      for (int i = 0; i < SIZE; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
        entries_d[i].br_en = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cdb_hit) begin
        entries_d[cdb_tag].done      = 1'b1;
        entries_d[cdb_tag].val       = cdb_val;
        entries_d[cdb_tag].br_en     = cdb_br_en;
        entries_d[cdb_tag].br_target = cdb_br_target;
      end
      if (do_dispatch) begin
        // br_target holds the PC until the writeback supplies the real target.
        entries_d[tail_q] = '{valid: 1'b1, done: 1'b0, rds: dispatch_rd,
                              val: 32'd0, br_en: 1'b0, br_target: dispatch_pc};
        tail_d = tail_q + 1'b1;
      end
      if (do_commit) begin
        entries_d[head_q].valid = 1'b0;
        entries_d[head_q].done  = 1'b0;
        head_d = head_q + 1'b1;
      end
      count_d = count_q + (TW+1)'(do_dispatch) - (TW+1)'(do_commit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++)
        entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    ready          = do_commit;
    ROB_commit_tag = head_q;
    rob_entry      = tail_q;
    rdest          = '0;
    if (do_commit) begin
      rdest.rds       = head_e.rds;
      rdest.ROB_val   = head_e.val;
      rdest.br_en     = head_e.br_en;
      rdest.br_target = head_e.br_target;
    end
    // Bypass from the CDB is suppressed while reset is held.
    {val1_ready, val1} = rst ? 33'd0 :
      lookup(tag1_valid, tag_in1, entries_q[tag_in1], cdb_valid, cdb_tag, cdb_val);
    {val2_ready, val2} = rst ? 33'd0 :
      lookup(tag2_valid, tag_in2, entries_q[tag_in2], cdb_valid, cdb_tag, cdb_val);
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed scoreboard bench for reorder_buffer
module tb_reorder_buffer;
  import rv32i_types::*;

  logic        clk, rst, dispatch;
  logic [4:0]  dispatch_rd;
  logic [31:0] dispatch_pc;
  logic        rob_full;
  logic [3:0]  rob_entry;
  logic        cdb_valid, cdb_br_en;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val, cdb_br_target;
  logic        ready;
  rob_t        rdest;
  logic [3:0]  ROB_commit_tag;
  logic [3:0]  tag_in1, tag_in2;
  logic        tag1_valid, tag2_valid;
  logic [31:0] val1, val2;
  logic        val1_ready, val2_ready;

  reorder_buffer #(.SIZE(16)) dut (
    .clk(clk), .rst(rst),
    .dispatch(dispatch), .dispatch_rd(dispatch_rd), .dispatch_pc(dispatch_pc),
    .rob_full(rob_full), .rob_entry(rob_entry),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_br_en(cdb_br_en), .cdb_br_target(cdb_br_target),
    .ready(ready), .rdest(rdest), .ROB_commit_tag(ROB_commit_tag),
    .tag_in1(tag_in1), .tag_in2(tag_in2),
    .tag1_valid(tag1_valid), .tag2_valid(tag2_valid),
    .val1(val1), .val2(val2), .val1_ready(val1_ready), .val2_ready(val2_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tag;
    logic [4:0] rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_val [16];
  logic        exp_br  [16];
  logic [31:0] exp_tgt [16];
  logic [3:0]  exp_tail;
  logic [3:0]  prev_tag;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    dispatch = 0; dispatch_rd = '0; dispatch_pc = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_val = '0; cdb_br_en = 0; cdb_br_target = '0;
    tag_in1 = '0; tag_in2 = '0; tag1_valid = 0; tag2_valid = 0;
  endtask

  task automatic record(input logic [3:0] t, input logic [31:0] v,
                        input logic br, input logic [31:0] tgt);
    exp_val[t] = v; exp_br[t] = br; exp_tgt[t] = tgt;
  endtask

  task automatic drive_cdb(input logic [3:0] t, input logic [31:0] v,
                           input logic br, input logic [31:0] tgt);
    cdb_valid = 1; cdb_tag = t; cdb_val = v; cdb_br_en = br; cdb_br_target = tgt;
  endtask

  // Pops the scoreboard whenever the DUT presents a commit.
  task automatic monitor();
    exp_t e;
    if (ready === 1'b1) begin
      chk("commit_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("commit_tag", ROB_commit_tag, e.tag);
        chk("commit_rds", rdest.rds, e.rd);
        chk("commit_val", rdest.ROB_val, exp_val[e.tag]);
        chk("commit_br_en", rdest.br_en, exp_br[e.tag]);
        if (exp_br[e.tag]) begin
          chk("commit_br_target", rdest.br_target, exp_tgt[e.tag]);
          sb.delete();
        end
      end
    end
  endtask

  task automatic step();
    monitor();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_dispatch(input logic [4:0] rd, input logic accept);
    dispatch = 1; dispatch_rd = rd; dispatch_pc = 32'h1000 + {25'd0, rd, 2'b00};
    #1;
    chk("dispatch_tag", rob_entry, exp_tail);
    chk("dispatch_full", rob_full, !accept);
    if (accept) begin
      sb.push_back('{tag: exp_tail, rd: rd});
      exp_br[exp_tail] = 0;
    end
    step();
    if (accept) exp_tail = exp_tail + 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      #1;
      step();
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      exp_val[i] = '0; exp_br[i] = 0; exp_tgt[i] = '0;
    end
    rst = 1;
    clear_inputs();
    tag1_valid = 1; tag_in1 = 4'd0; tag2_valid = 1; tag_in2 = 4'd0;
    cdb_valid = 1; cdb_tag = 4'd0; cdb_val = 32'h1234;
    @(negedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_full", rob_full, 0);
    chk("rst_entry", rob_entry, 0);
    chk("rst_rdest", rdest, 0);
    chk("rst_commit_tag", ROB_commit_tag, 0);
    chk("rst_val1_ready", val1_ready, 0);
    chk("rst_val2_ready", val2_ready, 0);
    @(negedge clk);
    rst = 0;
    clear_inputs();
    exp_tail = '0;

    // Fill: tags 0..15, then a dropped 17th dispatch.
    for (int i = 0; i < 16; i++) do_dispatch(5'(i + 1), 1);
    #1;
    chk("full_after_16", rob_full, 1);
    chk("tail_after_16", rob_entry, 0);
    do_dispatch(5'd17, 0);
    #1;
    chk("full_after_17", rob_full, 1);
    chk("tail_after_17", rob_entry, 0);

    // Out-of-order writeback 2, 1, 0.
    drive_cdb(4'd2, 32'h20, 0, 0); record(4'd2, 32'h20, 0, 0); #1;
    chk("ooo_ready_w2", ready, 0); step();
    drive_cdb(4'd1, 32'h10, 0, 0); record(4'd1, 32'h10, 0, 0); #1;
    chk("ooo_ready_w1", ready, 0); step();
    drive_cdb(4'd0, 32'h00, 0, 0); record(4'd0, 32'h00, 0, 0); #1;
    chk("ooo_ready_w0", ready, 0); step();
    // Full with head done plus a dispatch: commit happens, dispatch dropped.
    dispatch = 1; dispatch_rd = 5'd18; dispatch_pc = 32'h2000;
    #1;
    chk("c0_ready", ready, 1);
    chk("c0_tag", ROB_commit_tag, 0);
    chk("c0_full", rob_full, 1);
    step();
    #1;
    chk("c1_ready", ready, 1);
    chk("c1_tag", ROB_commit_tag, 1);
    chk("full_drop_full", rob_full, 0);
    chk("full_drop_tail", rob_entry, 0);
    step();
    #1;
    chk("c2_ready", ready, 1);
    chk("c2_tag", ROB_commit_tag, 2);
    step();
    #1;
    chk("c3_not_ready", ready, 0);

    // Taken branch at tag 3 while 4..15 are valid.
    drive_cdb(4'd3, 32'h33, 1, 32'h80); record(4'd3, 32'h33, 1, 32'h80); #1;
    chk("br_ready_pre", ready, 0); step();
    dispatch = 1; dispatch_rd = 5'd19; dispatch_pc = 32'h3000;
    drive_cdb(4'd4, 32'h44, 0, 0);
    #1;
    chk("br_ready", ready, 1);
    chk("br_tag", ROB_commit_tag, 3);
    chk("br_en", rdest.br_en, 1);
    chk("br_target", rdest.br_target, 32'h80);
    step();
    exp_tail = '0;
    tag1_valid = 1; tag_in1 = 4'd4;
    #1;
    chk("flush_entry", rob_entry, 0);
    chk("flush_full", rob_full, 0);
    chk("flush_ready", ready, 0);
    chk("flush_tag4_dropped", val1_ready, 0);
    step();

    // Lookup with same-cycle bypass.
    for (int i = 0; i < 6; i++) do_dispatch(5'(20 + i), 1);
    tag1_valid = 1; tag_in1 = 4'd5; tag2_valid = 1; tag_in2 = 4'd5;
    drive_cdb(4'd5, 32'hDEAD, 0, 0); record(4'd5, 32'hDEAD, 0, 0);
    #1;
    chk("byp_val1", val1, 32'hDEAD);
    chk("byp_val1_ready", val1_ready, 1);
    chk("byp_val2", val2, 32'hDEAD);
    chk("byp_val2_ready", val2_ready, 1);
    step();
    tag1_valid = 1; tag_in1 = 4'd5; tag2_valid = 1; tag_in2 = 4'd4;
    #1;
    chk("stored_val1", val1, 32'hDEAD);
    chk("stored_val1_ready", val1_ready, 1);
    chk("pending_val2_ready", val2_ready, 0);
    step();
    tag_in1 = 4'd5;
    #1;
    chk("novalid_val1", val1, 0);
    chk("novalid_val1_ready", val1_ready, 0);
    step();

    // CDB write to the tail being dispatched is ignored.
    dispatch = 1; dispatch_rd = 5'd26; dispatch_pc = 32'h4000;
    drive_cdb(4'd6, 32'h66, 0, 0);
    #1;
    chk("tailw_tag", rob_entry, 6);
    sb.push_back('{tag: 4'd6, rd: 5'd26}); exp_br[6] = 0;
    step();
    exp_tail = exp_tail + 1'b1;
    tag1_valid = 1; tag_in1 = 4'd6;
    #1;
    chk("tailw_ignored", val1_ready, 0);
    step();
    for (int t = 0; t < 5; t++) begin
      drive_cdb(4'(t), 32'h100 + t, 0, 0); record(4'(t), 32'h100 + t, 0, 0);
      #1;
      step();
    end
    drive_cdb(4'd6, 32'h600, 0, 0); record(4'd6, 32'h600, 0, 0);
    #1;
    step();
    drain();
    #1;
    chk("idle_ready", ready, 0);
    chk("idle_tail", rob_entry, 7);

    // 20 dispatch/commit pairs, wrapping the pointers.
    prev_tag = '0;
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) begin
        dispatch = 1; dispatch_rd = 5'((k % 31) + 1);
        dispatch_pc = 32'h5000 + 32'(k * 4);
      end
      if (k >= 1) begin
        drive_cdb(prev_tag, 32'h1000 + 32'(k - 1), 0, 0);
        record(prev_tag, 32'h1000 + 32'(k - 1), 0, 0);
      end
      #1;
      if (k < 20) begin
        chk("wrap_tag", rob_entry, exp_tail);
        sb.push_back('{tag: exp_tail, rd: 5'((k % 31) + 1)});
        exp_br[exp_tail] = 0;
      end
      step();
      if (k < 20) begin
        prev_tag = exp_tail;
        exp_tail = exp_tail + 1'b1;
      end
    end
    drain();
    #1;
    chk("wrap_tail", rob_entry, 11);

    // Reset mid-operation.
    do_dispatch(5'd1, 1);
    do_dispatch(5'd2, 1);
    do_dispatch(5'd3, 1);
    drive_cdb(4'd11, 32'hAA, 0, 0); record(4'd11, 32'hAA, 0, 0);
    #1;
    step();
    #2;
    rst = 1;
    #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_full", rob_full, 0);
    chk("mid_rst_entry", rob_entry, 0);
    chk("mid_rst_commit_tag", ROB_commit_tag, 0);
    chk("mid_rst_rdest", rdest, 0);
    sb.delete();
    @(negedge clk);
    rst = 0;
    clear_inputs();
    exp_tail = '0;
    do_dispatch(5'd9, 1);
    drive_cdb(4'd0, 32'h99, 0, 0); record(4'd0, 32'h99, 0, 0);
    #1;
    step();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
